// File: rtl/mux_rr_arbiter.sv
// Round-robin arbiter driving a shared N:1 data mux from registered grant/sel state.
// Optional per-owner burst limit is enabled by defining ARB_MAX_BURST_EN.
module mux_rr_arbiter #(
    parameter int N         = 4,
    parameter int W         = 8,
    parameter int MAX_BURST = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N-1:0]         req,
    input  logic [N*W-1:0]       data_in,
    output logic [N-1:0]         grant,
    output logic [$clog2(N)-1:0] sel,
    output logic                 valid,
    output logic [W-1:0]         data_out
);
    localparam int PW = $clog2(N);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state_reg, state_next;
    logic [N-1:0]  grant_reg, grant_next;
    logic [PW-1:0] sel_reg, sel_next;
    logic [PW-1:0] ptr_reg, ptr_next;
    logic          valid_reg, valid_next;

    logic [N-1:0]  cand;
    logic          found;
    logic [PW-1:0] pick;
    logic [PW:0]   idx;
    logic [PW:0]   ptr_sum;
    logic [PW-1:0] ptr_after;
    logic          take;

    // The current owner is never a candidate, so a pre-empted or released
    // owner can only be chosen again after a full rotation.
    assign cand = req & ~grant_reg;

    always_comb begin
        found = 1'b0;
        pick  = '0;
        idx   = '0;
        for (int i = N - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_reg} + (PW+1)'(i);
            if (idx >= (PW+1)'(N)) begin
                idx = idx - (PW+1)'(N);
            end
            if (cand[idx[PW-1:0]]) begin
                found = 1'b1;
                pick  = idx[PW-1:0];
            end
        end
    end

    always_comb begin
        ptr_sum   = {1'b0, pick} + (PW+1)'(1);
        ptr_after = (ptr_sum == (PW+1)'(N)) ? '0 : ptr_sum[PW-1:0];
    end

`ifdef ARB_MAX_BURST_EN
    localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

    logic [7:0] burst_reg, burst_next;
`else
    logic unused_max_burst;
    assign unused_max_burst = ^MAX_BURST;
`endif

    always_comb begin
        state_next = state_reg;
        grant_next = grant_reg;
        sel_next   = sel_reg;
        valid_next = valid_reg;
        ptr_next   = ptr_reg;
        take       = 1'b0;
`ifdef ARB_MAX_BURST_EN
        burst_next = burst_reg;
`endif
        case (state_reg)
            IDLE: begin
                if (found) begin
                    take = 1'b1;
                end
            end
            BUSY: begin
                if (!req[sel_reg]) begin
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        state_next = IDLE;
                        grant_next = '0;
                        valid_next = 1'b0;
                    end
`ifdef ARB_MAX_BURST_EN
                end else if (burst_reg == BURST_LAST) begin
                    // Pre-empt only when someone else is waiting.
                    if (found) begin
                        take = 1'b1;
                    end else begin
                        burst_next = '0;
                    end
                end else begin
                    burst_next = burst_reg + 8'd1;
`endif
                end
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                valid_next = 1'b0;
            end
        endcase

        if (take) begin
            state_next       = BUSY;
            grant_next       = '0;
            grant_next[pick] = 1'b1;
            sel_next         = pick;
            valid_next       = 1'b1;
            ptr_next         = ptr_after;
`ifdef ARB_MAX_BURST_EN
            burst_next       = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            grant_reg <= '0;
            sel_reg   <= '0;
            valid_reg <= 1'b0;
            ptr_reg   <= '0;
`ifdef ARB_MAX_BURST_EN
            burst_reg <= '0;
`endif
        end else begin
            state_reg <= state_next;
            grant_reg <= grant_next;
            sel_reg   <= sel_next;
            valid_reg <= valid_next;
            ptr_reg   <= ptr_next;
`ifdef ARB_MAX_BURST_EN
            burst_reg <= burst_next;
`endif
        end
    end

    logic [W-1:0] lanes [N];

    for (genvar gi = 0; gi < N; gi++) begin : g_lane
        assign lanes[gi] = data_in[gi*W +: W];
    end

    assign grant    = grant_reg;
    assign sel      = sel_reg;
    assign valid    = valid_reg;
    assign data_out = valid_reg ? lanes[sel_reg] : '0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Scoreboard bench for mux_rr_arbiter (N=4, W=8, MAX_BURST=4); expected grant
// sequences are written out by hand per scenario.
module tb_mux_rr_arbiter;
    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req = '0;
    logic [N*W-1:0] data_in;
    logic [N-1:0]   grant;
    logic [1:0]     sel;
    logic           valid;
    logic [W-1:0]   data_out;

    logic [W-1:0] lane [N];

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct packed {
        logic [3:0] req;
        logic [3:0] grant;
        logic [1:0] sel;
        logic       valid;
    } step_t;

    step_t sb_q[$];

    mux_rr_arbiter #(.N(N), .W(W), .MAX_BURST(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .data_in  (data_in),
        .grant    (grant),
        .sel      (sel),
        .valid    (valid),
        .data_out (data_out)
    );

    always #5 clk = ~clk;

    assign data_in = {lane[3], lane[2], lane[1], lane[0]};

    function automatic step_t mk(logic [3:0] r, logic [3:0] g, logic [1:0] s, logic v);
        step_t x;
        x.req   = r;
        x.grant = g;
        x.sel   = s;
        x.valid = v;
        return x;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0;
        req   = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        step_t t[$];
        step_t e;
        logic [7:0] exp_d;
        rst_n = 1'b0;
        req   = 4'b1111;
        @(posedge clk);
        #1;
        n_tests++;
        if ({grant, sel, valid, data_out} !== 15'd0) begin
            n_fail++;
            $display("FAIL reset_hold: grant=%b sel=%0d valid=%b data=%h, want all zero", grant, sel, valid, data_out);
        end else begin
            $display("[TB] reset_hold grant=%b valid=%b data=%h ok", grant, valid, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        t.push_back(mk(4'b1111, 4'b0001, 2'd0, 1'b1));
        t.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        foreach (t[i]) begin
            sb_q.push_back(t[i]);
            req = t[i].req;
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            exp_d = e.valid ? lane[e.sel] : 8'h00;
            n_tests++;
            if ({grant, sel, valid, data_out} !== {e.grant, e.sel, e.valid, exp_d}) begin
                n_fail++;
                $display("FAIL reset[%0d]: req=%b got grant=%b sel=%0d valid=%b data=%h, want grant=%b sel=%0d valid=%b data=%h",
                         i, e.req, grant, sel, valid, data_out, e.grant, e.sel, e.valid, exp_d);
            end else begin
                $display("[TB] reset[%0d] req=%b grant=%b sel=%0d data=%h ok", i, e.req, grant, sel, data_out);
            end
        end
    endtask

    task automatic test_single();
        step_t t[$];
        step_t e;
        logic [7:0] exp_d;
        do_reset();
        t.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1));
        t.push_back(mk(4'b0100, 4'b0100, 2'd2, 1'b1));
        t.push_back(mk(4'b0000, 4'b0000, 2'd2, 1'b0));
        foreach (t[i]) begin
            sb_q.push_back(t[i]);
            req = t[i].req;
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            exp_d = e.valid ? lane[e.sel] : 8'h00;
            n_tests++;
            if ({grant, sel, valid, data_out} !== {e.grant, e.sel, e.valid, exp_d}) begin
                n_fail++;
                $display("FAIL single[%0d]: req=%b got grant=%b sel=%0d valid=%b data=%h, want grant=%b sel=%0d valid=%b data=%h",
                         i, e.req, grant, sel, valid, data_out, e.grant, e.sel, e.valid, exp_d);
            end else begin
                $display("[TB] single[%0d] req=%b grant=%b sel=%0d data=%h ok", i, e.req, grant, sel, data_out);
            end
        end
    endtask

    task automatic test_handoff();
        step_t t[$];
        step_t e;
        logic [7:0] exp_d;
        do_reset();
        t.push_back(mk(4'b0001, 4'b0001, 2'd0, 1'b1));
        t.push_back(mk(4'b1010, 4'b0010, 2'd1, 1'b1));
        t.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b1));
        t.push_back(mk(4'b0000, 4'b0000, 2'd3, 1'b0));
        foreach (t[i]) begin
            sb_q.push_back(t[i]);
            req = t[i].req;
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            exp_d = e.valid ? lane[e.sel] : 8'h00;
            n_tests++;
            if ({grant, sel, valid, data_out} !== {e.grant, e.sel, e.valid, exp_d}) begin
                n_fail++;
                $display("FAIL handoff[%0d]: req=%b got grant=%b sel=%0d valid=%b data=%h, want grant=%b sel=%0d valid=%b data=%h",
                         i, e.req, grant, sel, valid, data_out, e.grant, e.sel, e.valid, exp_d);
            end else begin
                $display("[TB] handoff[%0d] req=%b grant=%b sel=%0d data=%h ok", i, e.req, grant, sel, data_out);
            end
        end
    endtask

    // After the wrap the pointer sits at 1, so a later 1001 request picks 3, not 0.
    task automatic test_wrap();
        step_t t[$];
        step_t e;
        logic [7:0] exp_d;
        do_reset();
        t.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b1));
        t.push_back(mk(4'b0001, 4'b0001, 2'd0, 1'b1));
        t.push_back(mk(4'b1001, 4'b0001, 2'd0, 1'b1));
        t.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        t.push_back(mk(4'b1001, 4'b1000, 2'd3, 1'b1));
        t.push_back(mk(4'b0000, 4'b0000, 2'd3, 1'b0));
        foreach (t[i]) begin
            sb_q.push_back(t[i]);
            req = t[i].req;
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            exp_d = e.valid ? lane[e.sel] : 8'h00;
            n_tests++;
            if ({grant, sel, valid, data_out} !== {e.grant, e.sel, e.valid, exp_d}) begin
                n_fail++;
                $display("FAIL wrap[%0d]: req=%b got grant=%b sel=%0d valid=%b data=%h, want grant=%b sel=%0d valid=%b data=%h",
                         i, e.req, grant, sel, valid, data_out, e.grant, e.sel, e.valid, exp_d);
            end else begin
                $display("[TB] wrap[%0d] req=%b grant=%b sel=%0d data=%h ok", i, e.req, grant, sel, data_out);
            end
        end
    endtask

    task automatic test_back_to_back();
        step_t t[$];
        step_t e;
        logic [7:0] exp_d;
        do_reset();
        t.push_back(mk(4'b1111, 4'b0001, 2'd0, 1'b1));
        t.push_back(mk(4'b1110, 4'b0010, 2'd1, 1'b1));
        t.push_back(mk(4'b1100, 4'b0100, 2'd2, 1'b1));
        t.push_back(mk(4'b1000, 4'b1000, 2'd3, 1'b1));
        t.push_back(mk(4'b0111, 4'b0001, 2'd0, 1'b1));
        t.push_back(mk(4'b0000, 4'b0000, 2'd0, 1'b0));
        foreach (t[i]) begin
            sb_q.push_back(t[i]);
            req = t[i].req;
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            exp_d = e.valid ? lane[e.sel] : 8'h00;
            n_tests++;
            if ({grant, sel, valid, data_out} !== {e.grant, e.sel, e.valid, exp_d}) begin
                n_fail++;
                $display("FAIL b2b[%0d]: req=%b got grant=%b sel=%0d valid=%b data=%h, want grant=%b sel=%0d valid=%b data=%h",
                         i, e.req, grant, sel, valid, data_out, e.grant, e.sel, e.valid, exp_d);
            end else begin
                $display("[TB] b2b[%0d] req=%b grant=%b sel=%0d data=%h ok", i, e.req, grant, sel, data_out);
            end
        end
    endtask

    task automatic test_burst();
        step_t t[$];
        step_t e;
        logic [7:0] exp_d;
        do_reset();
        for (int i = 0; i < 10; i++) begin
`ifdef ARB_MAX_BURST_EN
            if (((i / 4) % 2) == 1) begin
                t.push_back(mk(4'b0011, 4'b0010, 2'd1, 1'b1));
            end else begin
                t.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b1));
            end
`else
            t.push_back(mk(4'b0011, 4'b0001, 2'd0, 1'b1));
`endif
        end
        for (int i = 0; i < 8; i++) begin
            t.push_back(mk(4'b0001, 4'b0001, 2'd0, 1'b1));
        end
        foreach (t[i]) begin
            sb_q.push_back(t[i]);
            req = t[i].req;
            @(posedge clk);
            #1;
            e = sb_q.pop_front();
            exp_d = e.valid ? lane[e.sel] : 8'h00;
            n_tests++;
            if ({grant, sel, valid, data_out} !== {e.grant, e.sel, e.valid, exp_d}) begin
                n_fail++;
                $display("FAIL burst[%0d]: req=%b got grant=%b sel=%0d valid=%b data=%h, want grant=%b sel=%0d valid=%b data=%h",
                         i, e.req, grant, sel, valid, data_out, e.grant, e.sel, e.valid, exp_d);
            end else begin
                $display("[TB] burst[%0d] req=%b grant=%b sel=%0d data=%h ok", i, e.req, grant, sel, data_out);
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        req = 4'b0100;
        @(posedge clk);
        #1;
        n_tests++;
        if ({grant, sel, valid, data_out} !== {4'b0100, 2'd2, 1'b1, lane[2]}) begin
            n_fail++;
            $display("FAIL async_pre: grant=%b sel=%0d valid=%b data=%h, want grant=0100 sel=2 valid=1 data=%h",
                     grant, sel, valid, data_out, lane[2]);
        end else begin
            $display("[TB] async_pre req=%b grant=%b sel=%0d data=%h ok", req, grant, sel, data_out);
        end
        #2;
        rst_n = 1'b0;
        req   = 4'b1111;
        #1;
        n_tests++;
        if ({grant, sel, valid, data_out} !== 15'd0) begin
            n_fail++;
            $display("FAIL async_mid: grant=%b sel=%0d valid=%b data=%h, want all zero", grant, sel, valid, data_out);
        end else begin
            $display("[TB] async_mid grant=%b valid=%b data=%h ok", grant, valid, data_out);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if ({grant, sel, valid, data_out} !== {4'b0001, 2'd0, 1'b1, lane[0]}) begin
            n_fail++;
            $display("FAIL async_post: grant=%b sel=%0d valid=%b data=%h, want grant=0001 sel=0 valid=1 data=%h",
                     grant, sel, valid, data_out, lane[0]);
        end else begin
            $display("[TB] async_post req=%b grant=%b sel=%0d data=%h ok", req, grant, sel, data_out);
        end
        req = '0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, want completion");
        $fatal(1, "timeout");
    end

    initial begin
        lane[0] = 8'h11;
        lane[1] = 8'h5A;
        lane[2] = 8'hA5;
        lane[3] = 8'h3C;
        test_reset();
        test_single();
        test_handoff();
        test_wrap();
        test_back_to_back();
        test_burst();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
